multicycle_controller: RTL and testbench

Sequencing FSM for the multi-cycle RV32I core: it steps a single shared ALU, memory port, register file and PC through fetch, decode, execute, memory and writeback for R, I-ALU, load, store and BEQ instructions. It sits beside the datapath, takes the latched opcode, the ALU zero flag and a memory ready handshake, and drives every datapath mux select and write enable. It also counts retired instructions.

---
 rtl/rv_ctrl_pkg.sv | 85 ++++++++
 rtl/mc_ctrl_outputs.sv | 73 +++++++
 rtl/multicycle_controller.sv | 98 +++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and datapath.
// Combinational helpers only; no latency, no flow control.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BEQ       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_RFN = 2'b10,
        ALU_IFN = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I  = 2'b00,
        IMM_S  = 2'b01,
        IMM_LD = 2'b10,
        IMM_B  = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_READDATA  = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        pc_write;
        logic        ir_write;
        logic        reg_write;
        logic        mem_write;
        logic        adr_src;
        logic        branch;
        logic        illegal;
        src_a_t      src_a;
        src_b_t      src_b;
        result_src_t result_src;
        alu_op_t     alu_op;
        imm_src_t    imm_src;
    } ctrl_t;

    function automatic imm_src_t imm_decode(input logic [6:0] op);
        case (op)
            OP_STORE: return IMM_S;
            OP_LOAD:  return IMM_LD;
            OP_BEQ:   return IMM_B;
            default:  return IMM_I;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Control-bundle decode from state, opcode, zero flag and memory ready.
// Purely combinational: zero latency, memory stalls are reflected in the enables the same cycle.
module mc_ctrl_outputs
    import rv_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o         = '0;
        ctrl_o.imm_src = imm_decode(opcode_i);
        case (state_i)
            S_FETCH: begin
                ctrl_o.src_a      = SRCA_PC;
                ctrl_o.src_b      = SRCB_FOUR;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target computed here lands in ALUOut.
                ctrl_o.src_a   = SRCA_OLDPC;
                ctrl_o.src_b   = SRCB_IMM;
                ctrl_o.illegal = ~is_legal(opcode_i);
            end
            S_MEM_ADR: begin
                ctrl_o.src_a = SRCA_RS1;
                ctrl_o.src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_MEM_WB: begin
                ctrl_o.result_src = RES_READDATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.adr_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.src_a  = SRCA_RS1;
                ctrl_o.src_b  = SRCB_RS2;
                ctrl_o.alu_op = ALU_RFN;
            end
            S_EXEC_I: begin
                ctrl_o.src_a  = SRCA_RS1;
                ctrl_o.src_b  = SRCB_IMM;
                ctrl_o.alu_op = ALU_IFN;
            end
            S_ALU_WB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.src_a      = SRCA_RS1;
                ctrl_o.src_b      = SRCB_RS2;
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.branch     = 1'b1;
                ctrl_o.pc_write   = zero_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM with retired-instruction counter.
// State/Instret registered, controls combinational; Mem_Ready low holds FETCH/MEM_READ/MEM_WRITE.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             IR_Write,
    output logic             Reg_Write,
    output logic             Mem_Write,
    output logic             Adr_Src,
    output logic             Branch,
    output logic [1:0]       ALU_Src_A,
    output logic [1:0]       ALU_Src_B,
    output logic [1:0]       Result_Src,
    output logic [1:0]       ALU_Op,
    output logic [1:0]       Imm_Src,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Instret
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    ctrl_t            ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = Mem_Ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                if (Opcode == OP_LOAD)       state_d = S_MEM_READ;
                else if (Opcode == OP_STORE) state_d = S_MEM_WRITE;
                else                         state_d = S_FETCH;
            end
            S_MEM_READ:  state_d = Mem_Ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = Mem_Ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R,
            S_EXEC_I:    state_d = S_ALU_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // Illegal opcodes leave DECODE without retiring, so they never count.
    assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) || (state_q == S_BEQ) ||
                    ((state_q == S_MEM_WRITE) && Mem_Ready);
    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    mc_ctrl_outputs u_outputs (
        .state_i     (state_q),
        .opcode_i    (Opcode),
        .zero_i      (Zero),
        .mem_ready_i (Mem_Ready),
        .ctrl_o      (ctrl)
    );

    assign PC_Write   = ctrl.pc_write  & ~rst;
    assign IR_Write   = ctrl.ir_write  & ~rst;
    assign Reg_Write  = ctrl.reg_write & ~rst;
    assign Mem_Write  = ctrl.mem_write & ~rst;
    assign Adr_Src    = ctrl.adr_src;
    assign Branch     = ctrl.branch;
    assign Illegal    = ctrl.illegal;
    assign ALU_Src_A  = ctrl.src_a;
    assign ALU_Src_B  = ctrl.src_b;
    assign Result_Src = ctrl.result_src;
    assign ALU_Op     = ctrl.alu_op;
    assign Imm_Src    = ctrl.imm_src;
    assign State      = state_q;
    assign Instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against an instruction-level model of the controller.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  Opcode;
    logic        Zero, Mem_Ready;
    logic        PC_Write, IR_Write, Reg_Write, Mem_Write, Adr_Src, Branch, Illegal;
    logic [1:0]  ALU_Src_A, ALU_Src_B, Result_Src, ALU_Op, Imm_Src;
    logic [3:0]  State;
    logic [31:0] Instret;

    logic        s_pcw, s_irw, s_rw, s_mw, s_adr, s_br, s_ill;
    logic [1:0]  s_a, s_b, s_rs, s_op, s_imm;
    logic [3:0]  s_state;
    logic [2:0]  s_instret;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .IR_Write(IR_Write), .Reg_Write(Reg_Write), .Mem_Write(Mem_Write),
        .Adr_Src(Adr_Src), .Branch(Branch), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B),
        .Result_Src(Result_Src), .ALU_Op(ALU_Op), .Imm_Src(Imm_Src), .Illegal(Illegal),
        .State(State), .Instret(Instret)
    );

    // Narrow counter copy used to observe wrap-around quickly.
    multicycle_controller #(.CNT_W(3)) u_small (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .PC_Write(s_pcw), .IR_Write(s_irw), .Reg_Write(s_rw), .Mem_Write(s_mw),
        .Adr_Src(s_adr), .Branch(s_br), .ALU_Src_A(s_a), .ALU_Src_B(s_b),
        .Result_Src(s_rs), .ALU_Op(s_op), .Imm_Src(s_imm), .Illegal(s_ill),
        .State(s_state), .Instret(s_instret)
    );

    int          checks = 0;
    int          errors = 0;
    bit          exp_vld = 1'b0;
    logic [20:0] exp_vec;
    logic [31:0] cnt = '0;
    logic [63:0] seq;
    int          ncyc, mwc, ill_cnt;
    logic        pcw9, br9;

    wire [20:0] act_vec = {State, PC_Write, IR_Write, Reg_Write, Mem_Write, Adr_Src, Branch,
                           Illegal, ALU_Src_A, ALU_Src_B, Result_Src, ALU_Op, Imm_Src};

    function automatic bit legal(input logic [6:0] o);
        return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
               o == 7'b0100011 || o == 7'b1100011;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b0000011: return 2'b10;
            7'b1100011: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [20:0] expect_outs(input logic [3:0] st, input logic [6:0] o,
                                                input logic mr, input logic z);
        logic pcw, irw, rw, mw, adr, br, ill;
        logic [1:0] a, b, rs, op;
        {pcw, irw, rw, mw, adr, br, ill} = '0;
        {a, b, rs, op} = '0;
        case (st)
            4'd0: begin a = 2'd0; b = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
            4'd1: begin a = 2'd1; b = 2'd1; ill = !legal(o); end
            4'd2: begin a = 2'd2; b = 2'd1; end
            4'd3: adr = 1'b1;
            4'd4: begin rs = 2'd1; rw = 1'b1; end
            4'd5: begin adr = 1'b1; mw = 1'b1; end
            4'd6: begin a = 2'd2; b = 2'd0; op = 2'd2; end
            4'd7: begin a = 2'd2; b = 2'd1; op = 2'd3; end
            4'd8: rw = 1'b1;
            4'd9: begin a = 2'd2; op = 2'd1; br = 1'b1; pcw = z; end
            default: ;
        endcase
        return {st, pcw, irw, rw, mw, adr, br, ill, a, b, rs, op, imm_of(o)};
    endfunction

    always @(negedge clk) begin
        if (exp_vld) begin
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL ctrl t=%0t got %h want %h", $time, act_vec, exp_vec);
            end
            checks++;
            if (Instret !== cnt || s_instret !== cnt[2:0]) begin
                errors++;
                $display("FAIL instret got %0d/%0d want %0d/%0d", Instret, s_instret, cnt, cnt[2:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Entry and exit at one time unit after a rising edge. zmode: 0/1 fixed Zero, 2 random.
    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input int zmode);
        logic [3:0] sq[$];
        bit         mq[$];
        for (int i = 0; i < fw; i++) begin sq.push_back(4'd0); mq.push_back(1'b0); end
        sq.push_back(4'd0); mq.push_back(1'b1);
        sq.push_back(4'd1); mq.push_back(rb());
        case (opc)
            7'b0110011: begin sq.push_back(4'd6); mq.push_back(rb()); sq.push_back(4'd8); mq.push_back(rb()); end
            7'b0010011: begin sq.push_back(4'd7); mq.push_back(rb()); sq.push_back(4'd8); mq.push_back(rb()); end
            7'b0000011: begin
                sq.push_back(4'd2); mq.push_back(rb());
                for (int i = 0; i < mw; i++) begin sq.push_back(4'd3); mq.push_back(1'b0); end
                sq.push_back(4'd3); mq.push_back(1'b1);
                sq.push_back(4'd4); mq.push_back(rb());
            end
            7'b0100011: begin
                sq.push_back(4'd2); mq.push_back(rb());
                for (int i = 0; i < mw; i++) begin sq.push_back(4'd5); mq.push_back(1'b0); end
                sq.push_back(4'd5); mq.push_back(1'b1);
            end
            7'b1100011: begin sq.push_back(4'd9); mq.push_back(rb()); end
            default: ;
        endcase
        seq = '0; ncyc = 0; mwc = 0; ill_cnt = 0; pcw9 = 1'b0; br9 = 1'b0;
        for (int i = 0; i < sq.size(); i++) begin
            Opcode    = opc;
            Mem_Ready = mq[i];
            Zero      = (zmode == 2) ? rb() : 1'(zmode);
            exp_vec   = expect_outs(sq[i], opc, mq[i], Zero);
            exp_vld   = 1'b1;
            @(negedge clk);
            seq = {seq[59:0], State};
            ncyc++;
            if (Mem_Write) mwc++;
            if (Illegal) ill_cnt++;
            if (State == 4'd9) begin pcw9 = PC_Write; br9 = Branch; end
            @(posedge clk); #1;
        end
        if (legal(opc)) cnt = cnt + 1;
    endtask

    initial begin
        logic [6:0] ops[5];
        logic [6:0] o;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;

        rst = 1'b1; Opcode = 7'b0110011; Zero = 1'b1; Mem_Ready = 1'b1;
        #2;
        chk("rst_state", 64'(State), 64'd0);
        chk("rst_instret", 64'(Instret), 64'd0);
        chk("rst_enables", 64'({PC_Write, IR_Write, Reg_Write, Mem_Write}), 64'd0);
        chk("rst_fetch_srcb", 64'(ALU_Src_B), 64'd2);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(7'b0110011, 0, 0, 2);
        chk("r_seq", seq, 64'h0168);
        chk("r_instret", 64'(Instret), 64'd1);

        run_instr(7'b0000011, 0, 3, 2);
        chk("load_seq", seq, 64'h01233334);
        chk("load_cycles", 64'(ncyc), 64'd8);

        run_instr(7'b0100011, 0, 2, 2);
        chk("store_seq", seq, 64'h012555);
        chk("store_mw_cycles", 64'(mwc), 64'd3);

        run_instr(7'b1100011, 0, 0, 1);
        chk("beq_taken", {seq[15:0], 6'b0, pcw9, br9}, {16'h019, 8'h03});
        run_instr(7'b1100011, 0, 0, 0);
        chk("beq_not_taken", {seq[15:0], 6'b0, pcw9, br9}, {16'h019, 8'h01});

        run_instr(7'b1111111, 0, 0, 2);
        chk("illegal_seq", seq, 64'h01);
        chk("illegal_pulse", 64'(ill_cnt), 64'd1);
        chk("illegal_instret", 64'(Instret), 64'd5);

        run_instr(7'b0010011, 2, 0, 2);
        chk("fetch_wait_seq", seq, 64'h000178);

        for (int n = 0; n < 150; n++) begin
            o = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) o = 7'($urandom);
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), 2);
        end

        for (int n = 0; n < 8 && s_instret != 3'd7; n++) run_instr(7'b0110011, 0, 0, 2);
        chk("wrap_pre", 64'(s_instret), 64'd7);
        run_instr(7'b0010011, 0, 0, 2);
        chk("wrap_post", 64'(s_instret), 64'd0);

        exp_vld = 1'b0;
        Opcode = 7'b0000011; Mem_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        Mem_Ready = 1'b0;
        chk("pre_rst_memread", 64'(State), 64'd3);
        Mem_Ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_state", 64'(State), 64'd0);
        chk("async_rst_instret", 64'(Instret), 64'd0);
        chk("async_rst_enables", 64'({PC_Write, IR_Write, Reg_Write, Mem_Write}), 64'd0);
        cnt = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(7'b0110011, 0, 0, 2);
        chk("post_rst_instret", 64'(Instret), 64'd1);

        exp_vld = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
